// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates COUNT multiplier products into a wide sum over valid/ready handshakes
// Optional: PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum at 2^ACC_W-1 on carry-out instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic [SUM_W-1:0] w_add;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [3:0]       w_cnt_nxt;

    assign w_add     = {1'b0, r_acc} + SUM_W'(product);
    assign w_carry   = w_add[ACC_W];
    assign w_cnt_nxt = r_cnt + 4'd1;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_nxt = w_add[ACC_W-1:0];
`endif

    // Handshake flags depend on state only, so out_ready never reaches in_ready.
    assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign out_valid = (r_state == S_HOLD);
    assign sum       = r_acc;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= ACC_W'(product);
                        r_cnt   <= 4'd1;
                        r_state <= (COUNT == 1) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_cnt_nxt == 4'(COUNT)) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator (default and 10-bit/8-product instances)
module tb_product_accumulator;

    localparam int AW0 = 12;
    localparam int C0  = 4;
    localparam int AW1 = 10;
    localparam int C1  = 8;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           a_clear, a_iv, a_irdy, a_ov, a_ordy, a_ovf;
    logic [7:0]     a_p;
    logic [AW0-1:0] a_sum;
    logic           b_clear, b_iv, b_irdy, b_ov, b_ordy, b_ovf;
    logic [7:0]     b_p;
    logic [AW1-1:0] b_sum;

    product_accumulator #(.ACC_W(AW0), .COUNT(C0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_iv), .in_ready(a_irdy),
        .product(a_p), .out_valid(a_ov), .out_ready(a_ordy), .sum(a_sum), .ovf(a_ovf)
    );

    product_accumulator #(.ACC_W(AW1), .COUNT(C1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_iv), .in_ready(b_irdy),
        .product(b_p), .out_valid(b_ov), .out_ready(b_ordy), .sum(b_sum), .ovf(b_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_acc [2];
    int m_cnt [2];
    bit m_ovf [2];
    bit m_hold[2];
    int q0[$];
    int q1[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_acc[d]  = 0;
        m_cnt[d]  = 0;
        m_ovf[d]  = 1'b0;
        m_hold[d] = 1'b0;
    endtask

    // One cycle on instance d: check visible outputs, drive inputs, advance the reference model.
    task automatic cycle(input int d, input bit iv, input logic [7:0] p, input bit ordy, input bit clr);
        logic irdy, ov, of;
        int   sm, e, aw, cmax, tot;
        @(negedge clk);
        aw   = (d == 0) ? AW0 : AW1;
        cmax = (d == 0) ? C0 : C1;
        if (d == 0) begin
            irdy = a_irdy; ov = a_ov; of = a_ovf; sm = int'(a_sum);
        end else begin
            irdy = b_irdy; ov = b_ov; of = b_ovf; sm = int'(b_sum);
        end
        check_eq("in_ready", 32'(irdy), 32'(!m_hold[d]));
        check_eq("out_valid", 32'(ov), 32'(m_hold[d]));
        check_eq("sum_live", 32'(sm), 32'(m_acc[d]));
        check_eq("ovf_live", 32'(of), 32'(m_ovf[d]));
        if (ov && ordy && !clr) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check_eq("sum_out", 32'(sm), 32'(e & 32'hFFFF));
                check_eq("ovf_out", 32'(of), 32'(e >> 16));
            end
        end
        if (d == 0) begin
            a_iv = iv; a_p = p; a_ordy = ordy; a_clear = clr;
        end else begin
            b_iv = iv; b_p = p; b_ordy = ordy; b_clear = clr;
        end
        if (clr) begin
            if (m_hold[d]) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            model_reset(d);
        end else if (m_hold[d]) begin
            if (ordy) model_reset(d);
        end else if (iv) begin
            tot = m_acc[d] + int'(p);
            if (tot >= (1 << aw)) begin
                m_ovf[d] = 1'b1;
                m_acc[d] = SAT ? ((1 << aw) - 1) : (tot - (1 << aw));
            end else begin
                m_acc[d] = tot;
            end
            m_cnt[d]++;
            if (m_cnt[d] == cmax) begin
                m_hold[d] = 1'b1;
                if (d == 0) q0.push_back((int'(m_ovf[d]) << 16) | m_acc[d]);
                else        q1.push_back((int'(m_ovf[d]) << 16) | m_acc[d]);
            end
        end
    endtask

    logic [7:0] bub_p [8] = '{8'd1, 8'hFF, 8'd2, 8'hAA, 8'd4, 8'h55, 8'd8, 8'h00};

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_iv = 0; a_p = 0; a_ordy = 0;
        b_clear = 0; b_iv = 0; b_p = 0; b_ordy = 0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        check_eq("rst_sum", 32'(a_sum), 32'd0);
        check_eq("rst_ovf", 32'(a_ovf), 32'd0);
        check_eq("rst_out_valid", 32'(a_ov), 32'd0);
        check_eq("rst_in_ready", 32'(a_irdy), 32'd1);
        check_eq("rst_in_ready_b", 32'(b_irdy), 32'd1);
        rst_n = 1'b1;

        // Back-to-back 3,10,225,0 -> 238
        cycle(0, 1, 8'd3, 1, 0);
        cycle(0, 1, 8'd10, 1, 0);
        cycle(0, 1, 8'd225, 1, 0);
        cycle(0, 1, 8'd0, 1, 0);
        cycle(0, 0, 8'd0, 1, 0);
        cycle(0, 0, 8'd0, 1, 0);

        // Bubbles with junk on product while invalid, then 5 cycles of backpressure
        for (int i = 0; i < 8; i++) cycle(0, (i % 2) == 0, bub_p[i], 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'd9, 0, 0);
        cycle(0, 0, 8'd0, 1, 0);
        cycle(0, 0, 8'd0, 0, 0);

        // Overflow on the 10-bit, 8-product instance
        for (int i = 0; i < 8; i++) cycle(1, 1, 8'd225, 0, 0);
        cycle(1, 1, 8'd225, 0, 0);
        cycle(1, 0, 8'd0, 1, 0);
        cycle(1, 0, 8'd0, 0, 0);

        // Clear mid-accumulation drops the offered product; clear in HOLD discards the result
        cycle(0, 1, 8'd50, 0, 0);
        cycle(0, 1, 8'd60, 0, 0);
        cycle(0, 1, 8'd99, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'd7, 0, 0);
        cycle(0, 0, 8'd0, 0, 0);
        cycle(0, 0, 8'd0, 1, 1);
        cycle(0, 0, 8'd0, 1, 0);

        // Asynchronous reset between edges mid-accumulation
        cycle(0, 1, 8'd40, 0, 0);
        cycle(0, 1, 8'd41, 0, 0);
        cycle(0, 0, 8'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sum", 32'(a_sum), 32'd0);
        check_eq("arst_ovf", 32'(a_ovf), 32'd0);
        check_eq("arst_out_valid", 32'(a_ov), 32'd0);
        check_eq("arst_in_ready", 32'(a_irdy), 32'd1);
        model_reset(0);
        model_reset(1);
        #1;
        rst_n = 1'b1;
        cycle(0, 1, 8'd100, 0, 0);
        cycle(0, 1, 8'd200, 0, 0);
        cycle(0, 1, 8'd255, 0, 0);
        cycle(0, 1, 8'd1, 0, 0);
        cycle(0, 0, 8'd0, 1, 0);
        cycle(0, 0, 8'd0, 0, 0);

        check_eq("sb_left0", 32'(q0.size()), 32'd0);
        check_eq("sb_left1", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
